// File: rtl/class_argmax_ctrl.sv
// class_argmax_ctrl: captures NUM_CLASSES signed class sums on a rising edge of
// product_rdy, scans them one per cycle for the maximum, and reports the winning
// index, its score, the winner-to-runner-up margin and a 7-segment digit.
module class_argmax_ctrl #(
  parameter int NUM_CLASSES = 10,
  parameter int SUM_WIDTH   = 32,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             product_rdy,
  input  logic [NUM_CLASSES*SUM_WIDTH-1:0] sums_in,
  output logic                             busy,
  output logic                             class_valid,
  output logic [IDX_WIDTH-1:0]             class_idx,
  output logic [SUM_WIDTH-1:0]             class_max,
  output logic [SUM_WIDTH:0]               margin,
  output logic [6:0]                       hex_seg,
  output logic [7:0]                       drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0]        LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic signed [SUM_WIDTH-1:0] MOST_NEG = {1'b1, {(SUM_WIDTH-1){1'b0}}};

  state_t                       state;
  state_t                       state_next;
  logic                         rdy_p1;
  logic                         trigger;
  logic                         capture;
  logic                         drop;

  logic signed [SUM_WIDTH-1:0]  bank [NUM_CLASSES];
  logic signed [SUM_WIDTH-1:0]  best;
  logic signed [SUM_WIDTH-1:0]  second;
  logic signed [SUM_WIDTH-1:0]  cand;
  logic [IDX_WIDTH-1:0]         best_idx;
  logic [IDX_WIDTH-1:0]         scan_idx;

  // best minus second at one extra bit so the full signed range never overflows
  function automatic logic [SUM_WIDTH:0] calc_margin(
    input logic signed [SUM_WIDTH-1:0] hi,
    input logic signed [SUM_WIDTH-1:0] lo
  );
    logic signed [SUM_WIDTH:0] hi_x;
    logic signed [SUM_WIDTH:0] lo_x;
    hi_x = {hi[SUM_WIDTH-1], hi};
    lo_x = {lo[SUM_WIDTH-1], lo};
    return hi_x - lo_x;
  endfunction

  // 8-bit counter increment that sticks at 255
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // active-low {g,f,e,d,c,b,a} pattern for a hex digit
  function automatic logic [6:0] hex_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign trigger = product_rdy & ~rdy_p1;
  assign drop    = trigger & ((state == SCAN) || (state == DONE));
  assign cand    = bank[scan_idx];

  // product_rdy history for rising-edge detection; cleared so a high first sample counts
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdy_p1 <= 1'b0;
    end else begin
      rdy_p1 <= product_rdy;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: capture on trigger, scan one class per cycle, then publish
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          capture    = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (scan_idx == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---- stage p0: capture bank and run the sequential max / runner-up scan ----
  always_ff @(posedge clock) begin
    if (capture) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        bank[k] <= sums_in[k*SUM_WIDTH +: SUM_WIDTH];
      end
      best     <= sums_in[0 +: SUM_WIDTH];
      second   <= MOST_NEG;
      best_idx <= '0;
      scan_idx <= IDX_WIDTH'(1);
    end else if (state == SCAN) begin
      // strict compare keeps the lower index on ties; the tied value becomes runner-up
      if (cand > best) begin
        second   <= best;
        best     <= cand;
        best_idx <= scan_idx;
      end else if (cand > second) begin
        second <= cand;
      end
      scan_idx <= scan_idx + IDX_WIDTH'(1);
    end
  end

  // ---- stage p1: publish result, valid pulse, busy flag and drop counter ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy        <= 1'b0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_max   <= '0;
      margin      <= '0;
      hex_seg     <= 7'h40;
      drop_count  <= 8'd0;
    end else begin
      class_valid <= (state == DONE);
      if (state == DONE) begin
        class_idx <= best_idx;
        class_max <= best;
        margin    <= calc_margin(best, second);
        hex_seg   <= hex_decode(4'(best_idx));
      end
      // busy covers the scan and the valid cycle, dropping one edge after the pulse
      if (capture) begin
        busy <= 1'b1;
      end else if (class_valid) begin
        busy <= 1'b0;
      end
      if (drop) begin
        drop_count <= sat_inc(drop_count);
      end
    end
  end

endmodule
